// File: rtl/conn_setup_sequencer.sv
// Connection-setup sequencer: takes one open/close request per handshake,
// serialises it into ConnSetupFrame commands for the RPC unit, waits for the
// connection-manager status and reports done/error.
//
// ConnSetupFrame layout (72 bits): [71:64] setup type, [63:0] data.
// Setup type codes follow the open-sequence order: 0 ConnId, 1 Open,
// 2 DestIPv4, 3 DestPort, 4 ClientFlowId, 5 QPFields, 6 QKey, 7 Enable.
//
// Request handshake: a request transfers on a cycle where req_valid and
// req_ready are both high; req_ready is high only while idle, the request
// fields are captured on that cycle and later input changes are ignored.
module conn_setup_sequencer #(
  parameter int NIC_ID         = 0,
  parameter int FRAME_GAP      = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_open,
  input  logic [31:0] req_conn_id,
  input  logic [31:0] req_dest_ip,
  input  logic [15:0] req_dest_port,
  input  logic [15:0] req_client_flow_id,
  input  logic [15:0] req_remote_qp_num,
  input  logic [15:0] req_p_key,
  input  logic [31:0] req_q_key,
  output logic        conn_setup_en_out,
  output logic [71:0] conn_setup_frame_out,
  input  logic        status_valid_in,
  input  logic        status_error_in,
  output logic        done_valid,
  output logic        done_error,
  output logic        busy,
  output logic [15:0] timeout_count,
  output logic [2:0]  state_dbg
);

  localparam int FRAME_W = 72;

  localparam logic [7:0] SETUP_CONN_ID   = 8'd0;
  localparam logic [7:0] SETUP_OPEN      = 8'd1;
  localparam logic [7:0] SETUP_DEST_IP   = 8'd2;
  localparam logic [7:0] SETUP_DEST_PORT = 8'd3;
  localparam logic [7:0] SETUP_FLOW_ID   = 8'd4;
  localparam logic [7:0] SETUP_QP_FIELDS = 8'd5;
  localparam logic [7:0] SETUP_Q_KEY     = 8'd6;
  localparam logic [7:0] SETUP_ENABLE    = 8'd7;

  // Gap counter is 4 bits wide, so larger gaps are clamped to 15.
  localparam int         GAP       = (FRAME_GAP > 15) ? 15 : ((FRAME_GAP < 0) ? 0 : FRAME_GAP);
  localparam logic [3:0] GAP_LAST  = 4'(GAP);
  // Wait counter is 0 in the first wait cycle; the last wait cycle is the one
  // in which it would step to TIMEOUT_CYCLES.
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);

  // NIC_ID only tags simulation messages; nothing in the datapath uses it.
  if (NIC_ID < 0) begin : g_nic_id_unused
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  frame_idx;
  logic [3:0]  gap_cnt;
  logic [31:0] wait_cnt;

  logic        open_q;
  logic [31:0] conn_id_q;
  logic [31:0] dest_ip_q;
  logic [15:0] dest_port_q;
  logic [15:0] flow_id_q;
  logic [15:0] qp_num_q;
  logic [15:0] p_key_q;
  logic [31:0] q_key_q;

  assign state_dbg = state;

  // Frame idx of the open or close sequence, data zero-extended to 64 bits.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic        open,
    input logic [2:0]  idx,
    input logic [31:0] conn_id,
    input logic [31:0] dest_ip,
    input logic [15:0] dest_port,
    input logic [15:0] flow_id,
    input logic [15:0] qp_num,
    input logic [15:0] p_key,
    input logic [31:0] q_key
  );
    logic [7:0]  kind;
    logic [63:0] data;
    if (open)
      kind = {5'd0, idx};
    else if (idx == 3'd0)
      kind = SETUP_CONN_ID;
    else if (idx == 3'd1)
      kind = SETUP_OPEN;
    else
      kind = SETUP_ENABLE;
    case (kind)
      SETUP_CONN_ID:   data = {32'd0, conn_id};
      SETUP_OPEN:      data = {63'd0, open};
      SETUP_DEST_IP:   data = {32'd0, dest_ip};
      SETUP_DEST_PORT: data = {48'd0, dest_port};
      SETUP_FLOW_ID:   data = {48'd0, flow_id};
      SETUP_QP_FIELDS: data = {32'd0, qp_num, p_key};
      SETUP_Q_KEY:     data = {32'd0, q_key};
      default:         data = 64'd0;
    endcase
    return {kind, data};
  endfunction

  // Sequencer FSM with registered handshake, frame and completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      frame_idx            <= '0;
      gap_cnt              <= '0;
      wait_cnt             <= '0;
      req_ready            <= 1'b1;
      conn_setup_en_out    <= 1'b0;
      conn_setup_frame_out <= '0;
      done_valid           <= 1'b0;
      done_error           <= 1'b0;
      busy                 <= 1'b0;
      timeout_count        <= '0;
      open_q               <= 1'b0;
      conn_id_q            <= '0;
      dest_ip_q            <= '0;
      dest_port_q          <= '0;
      flow_id_q            <= '0;
      qp_num_q             <= '0;
      p_key_q              <= '0;
      q_key_q              <= '0;
    end else begin
      conn_setup_en_out    <= 1'b0;
      conn_setup_frame_out <= '0;
      done_valid           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            open_q               <= req_open;
            conn_id_q            <= req_conn_id;
            dest_ip_q            <= req_dest_ip;
            dest_port_q          <= req_dest_port;
            flow_id_q            <= req_client_flow_id;
            qp_num_q             <= req_remote_qp_num;
            p_key_q              <= req_p_key;
            q_key_q              <= req_q_key;
            frame_idx            <= 3'd0;
            conn_setup_en_out    <= 1'b1;
            conn_setup_frame_out <= build_frame(req_open, 3'd0, req_conn_id, req_dest_ip,
                                                req_dest_port, req_client_flow_id,
                                                req_remote_qp_num, req_p_key, req_q_key);
            req_ready            <= 1'b0;
            busy                 <= 1'b1;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (frame_idx == (open_q ? 3'd7 : 3'd2)) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else if (GAP == 0) begin
            frame_idx            <= frame_idx + 3'd1;
            conn_setup_en_out    <= 1'b1;
            conn_setup_frame_out <= build_frame(open_q, frame_idx + 3'd1, conn_id_q, dest_ip_q,
                                                dest_port_q, flow_id_q, qp_num_q, p_key_q, q_key_q);
          end else begin
            gap_cnt <= 4'd1;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            frame_idx            <= frame_idx + 3'd1;
            conn_setup_en_out    <= 1'b1;
            conn_setup_frame_out <= build_frame(open_q, frame_idx + 3'd1, conn_id_q, dest_ip_q,
                                                dest_port_q, flow_id_q, qp_num_q, p_key_q, q_key_q);
            state                <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          // Status takes priority over a timeout expiring in the same cycle.
          if (status_valid_in) begin
            done_valid <= 1'b1;
            done_error <= status_error_in;
            state      <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            done_valid <= 1'b1;
            done_error <= 1'b1;
            if (timeout_count != 16'hFFFF)
              timeout_count <= timeout_count + 16'd1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
